// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Single-outstanding APB requester driven by a cmd/rsp handshake.
// Revision    : 1.0
// ============================================================================
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Counter is wide enough for TIMEOUT_CYCLES; at least one bit when disabled.
    localparam int c_CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int c_TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit c_TO_EN   = (TIMEOUT_CYCLES > 0);

    state_t                      r_state;
    logic [c_CW-1:0]             r_wait;
    logic                        r_psel;
    logic                        r_penable;
    logic                        r_pwrite;
    logic [APB_ADDR_WIDTH-1:0]   r_paddr;
    logic [APB_DATA_WIDTH-1:0]   r_pwdata;
    logic                        r_rsp_valid;
    logic [APB_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                        r_rsp_err;
    logic                        r_rsp_timeout;

    logic                        w_timeout_hit;
    logic                        w_wait_sat;

    assign w_timeout_hit = c_TO_EN && (r_wait == c_CW'(c_TO_LAST));
    assign w_wait_sat    = (r_wait == {c_CW{1'b1}});

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= S_IDLE;
            r_wait        <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite <= cmd_write;
                        r_paddr  <= cmd_addr;
                        r_pwdata <= cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A ready slave wins over a timeout expiring on the same edge.
                    if (PREADY) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (w_timeout_hit) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (!w_wait_sat) begin
                        r_wait <= r_wait + c_CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Directed self-checking bench for apb_master_bridge.
// Revision    : 1.0
// ============================================================================
module tb_apb_master_bridge;

    logic       clk;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err, rsp_timeout, busy;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready, pslverr;

    int         n_tests = 0;
    int         n_fail  = 0;

    // Slave model: PREADY rises on ACCESS cycle number ready_at (0 = never).
    int         ready_at = 0;
    int         acc_cnt  = 0;
    logic       slverr_v = 1'b0;

    apb_master_bridge #(
        .APB_ADDR_WIDTH (8),
        .APB_DATA_WIDTH (8),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .PCLK        (clk),
        .PRESET      (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .PSEL        (psel),
        .PENABLE     (penable),
        .PWRITE      (pwrite),
        .PADDR       (paddr),
        .PWDATA      (pwdata),
        .PRDATA      (prdata),
        .PREADY      (pready),
        .PSLVERR     (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    assign pready  = psel && penable && (ready_at != 0) && (acc_cnt == ready_at - 1);
    assign pslverr = pready && slverr_v;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one command and watches it until rsp_valid; leaves the response pending.
    task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input int rdy, input logic [7:0] rd, input logic se,
                           output int lat, output int psel_n, output int pen_n,
                           output int stable_ok);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        ready_at = rdy; prdata = rd; slverr_v = se;
        @(posedge clk);
        lat = 0; psel_n = 0; pen_n = 0; stable_ok = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (psel) psel_n++;
            if (penable) pen_n++;
            if (penable && !psel) stable_ok = 0;
            if (psel && (paddr !== a || pwrite !== w || (w && pwdata !== d))) stable_ok = 0;
            if (rsp_valid) break;
        end
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int lat, ps, pe, ok, seen;
    logic [7:0] held_rdata;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_cmd_ready", cmd_ready, 1);
        check_eq("reset_outs", {busy, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}, 0);
        check_eq("reset_paddr_pwdata_rdata", {paddr, pwdata, rsp_rdata}, 0);
        rst = 1'b0;

        // Write LCR, ready on 2nd ACCESS cycle; PRDATA garbage must not leak
        run_txn(1'b1, 8'h03, 8'h1B, 2, 8'hEE, 1'b0, lat, ps, pe, ok);
        check_eq("wr_latency", lat, 4);
        check_eq("wr_psel_cycles", ps, 3);
        check_eq("wr_penable_cycles", pe, 2);
        check_eq("wr_addr_data_stable", ok, 1);
        check_eq("wr_rsp", {rsp_rdata, 6'b0, rsp_err, rsp_timeout}, 32'h0);
        ack_rsp();
        check_eq("wr_idle_after", {busy, cmd_ready, psel}, 3'b010);
        check_eq("wr_hold_in_idle", {paddr, pwdata, 7'b0, pwrite}, {8'h03, 8'h1B, 8'h01});

        // Read FSR
        run_txn(1'b0, 8'h05, 8'hFF, 2, 8'h0A, 1'b0, lat, ps, pe, ok);
        check_eq("rd_latency", lat, 4);
        check_eq("rd_pwrite_low_stable", ok, 1);
        check_eq("rd_rsp", {rsp_rdata, rsp_err, rsp_timeout}, {8'h0A, 2'b00});
        ack_rsp();

        // Slave error on a zero-wait read
        run_txn(1'b0, 8'h08, 8'h00, 1, 8'h3C, 1'b1, lat, ps, pe, ok);
        check_eq("err_latency", lat, 3);
        check_eq("err_rsp", {rsp_rdata, rsp_err, rsp_timeout}, {8'h3C, 2'b10});
        ack_rsp();

        // Timeout: slave never ready
        run_txn(1'b0, 8'h07, 8'h00, 0, 8'h55, 1'b0, lat, ps, pe, ok);
        check_eq("to_penable_cycles", pe, 4);
        check_eq("to_latency", lat, 6);
        check_eq("to_rsp", {rsp_rdata, rsp_err, rsp_timeout}, {8'h00, 2'b11});
        ack_rsp();

        // Ready on the 4th ACCESS cycle beats the timeout
        run_txn(1'b0, 8'h07, 8'h00, 4, 8'h66, 1'b0, lat, ps, pe, ok);
        check_eq("to_edge_penable_cycles", pe, 4);
        check_eq("to_edge_rsp", {rsp_rdata, rsp_err, rsp_timeout}, {8'h66, 2'b00});

        // Backpressure: response pending, a new command waits at the port
        held_rdata = rsp_rdata;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h5A;
        ok = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (cmd_ready || psel || !rsp_valid || rsp_rdata !== held_rdata) ok = 0;
        end
        check_eq("bp_hold_and_ignore", ok, 1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("bp_idle_gap", {rsp_valid, psel, cmd_ready}, 3'b001);
        ready_at = 1; slverr_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("bp_next_setup", {psel, penable, paddr}, {2'b10, 8'h01});
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check_eq("bp_next_done", seen, 1);
        ack_rsp();

        // Reset during a wait state
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h09; ready_at = 0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_pre_in_access", {psel, penable}, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_outs", {psel, penable, busy, rsp_valid, cmd_ready}, 5'b00001);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid || psel) seen = 1;
        end
        check_eq("rst_no_rsp", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester that turns a simple command/response handshake into single APB transfers.
- Drives the register bank: used by the internal test/bring-up controller and by the host-side wrapper to program MDR/DLL/DLH/LCR/IER/TBR and to poll FSR/RBR.
- Handles one outstanding transfer at a time. A wait-state timeout aborts transfers when the slave never asserts PREADY.

Parameters:
- APB_ADDR_WIDTH, 8, width of PADDR and cmd_addr.
- APB_DATA_WIDTH, 8, width of PWDATA/PRDATA and the command/response data.
- TIMEOUT_CYCLES, 16, number of ACCESS cycles with PREADY low before the transfer is aborted. 0 disables the timeout.

Ports:
- PCLK  input  1  single clock, all logic on the rising edge.
- PRESET  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  APB_ADDR_WIDTH  target address.
- cmd_wdata  input  APB_DATA_WIDTH  write data, ignored for reads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  APB_DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  output  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  output  1  transfer aborted by the timeout.
- busy  output  1  high whenever the state is not IDLE.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  APB_ADDR_WIDTH  APB address.
- PWDATA  output  APB_DATA_WIDTH  APB write data.
- PRDATA  input  APB_DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Reset (PRESET high at a PCLK edge):
  - state goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy and the wait counter all go to 0.
  - cmd_ready = 1.
  - Reset mid-transfer drops PSEL/PENABLE at that same edge. The in-flight response is discarded and never reported.
- State machine: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All APB outputs are registered.
- IDLE:
  - cmd_ready = 1, PSEL = PENABLE = 0.
  - On cmd_valid (handshake at the edge), capture cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, set PSEL = 1, and go to SETUP.
- SETUP (exactly one cycle):
  - PSEL = 1, PENABLE = 0.
  - Next edge sets PENABLE = 1, clears the wait counter, and goes to ACCESS.
- ACCESS:
  - PSEL = PENABLE = 1. PADDR/PWDATA/PWRITE stay stable from SETUP through the end of ACCESS.
  - Edge with PREADY = 1: latch rsp_rdata = PRDATA (reads only, else 0), rsp_err = PSLVERR, rsp_timeout = 0. Clear PSEL/PENABLE, set rsp_valid = 1, go to RESP.
  - Edge with PREADY = 0: increment the wait counter.
  - If TIMEOUT_CYCLES != 0 and the counter already equals TIMEOUT_CYCLES - 1, abort: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Clear PSEL/PENABLE, go to RESP.
  - PREADY = 1 on the same edge as the timeout threshold takes priority: the transfer completes normally.
- RESP:
  - rsp_valid = 1. rsp_* stay stable until rsp_ready.
  - Edge with rsp_ready = 1: clear rsp_valid and go to IDLE. The next command can be accepted one cycle later.
  - PSEL = 0 throughout.
- Handshake rules:
  - cmd_ready is 0 in SETUP, ACCESS and RESP. cmd_valid held during busy is ignored, not queued.
  - PADDR/PWDATA/PWRITE keep their last values in IDLE (no X, no toggle).
- Latency:
  - Command accept to rsp_valid is 2 + N edges, where N = number of ACCESS cycles (N ≥ 1).
  - Against the register bank (PREADY registered), N = 2, giving rsp_valid 4 cycles after accept.
- Wait counter width: enough to hold TIMEOUT_CYCLES. The counter saturates and never wraps.
- The block never asserts PENABLE without a preceding SETUP cycle, and never has PENABLE = 1 while PSEL = 0.

Test Plan:
- Write LCR: cmd write addr 0x03 data 0x1B, slave PREADY high on 2nd ACCESS cycle.
  -> PSEL 1 for 3 cycles, PENABLE 1 for 2, PADDR = 0x03, PWDATA = 0x1B stable; rsp_valid 4 cycles after accept with rsp_err = 0, rsp_rdata = 0.
- Read FSR: cmd read addr 0x05, slave returns PRDATA = 0x0A with PREADY.
  -> rsp_rdata = 0x0A, rsp_err = 0, PWRITE = 0 throughout.
- Slave error: read addr 0x08 with PSLVERR = 1 at PREADY.
  -> rsp_err = 1, rsp_timeout = 0.
- Timeout: TIMEOUT_CYCLES = 4, PREADY tied 0.
  -> PENABLE high for exactly 4 cycles; rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  -> Also drive PREADY = 1 on the 4th ACCESS cycle: normal completion, rsp_timeout = 0.
- Backpressure and ignored commands: rsp_ready held low 5 cycles while cmd_valid stays high.
  -> rsp_* stable, cmd_ready = 0, no new PSEL.
  -> After rsp_ready, the next command starts SETUP 2 cycles later.
- Reset mid-ACCESS: PRESET pulsed during a wait state.
  -> PSEL/PENABLE = 0 at that edge, rsp_valid never asserts, cmd_ready = 1 after reset.
